// File: rtl/branch_target_predictor_if.sv
// Fetch-side lookup and Execute-side training bundle for the branch target predictor.
// master: pipeline (drives fetch/update, reads prediction); slave: predictor.
interface branch_target_predictor_if #(
  parameter int IDX_W  = 6,
  parameter int MISS_W = 16
);
  logic              enable;
  logic [31:0]       fetchAddress;
  logic              branchPredictValid;
  logic [31:0]       branchPredictData;
  logic [IDX_W-1:0]  predictIndex;
  logic              updateValid;
  logic [IDX_W-1:0]  updateIndex;
  logic [31:0]       updateAddress;
  logic              updateIsBranch;
  logic              updateTaken;
  logic [31:0]       updateTarget;
  logic              updateMispredict;
  logic [MISS_W-1:0] mispredictCount;

  modport master (
    output enable, fetchAddress,
    output updateValid, updateIndex, updateAddress,
    output updateIsBranch, updateTaken, updateTarget,
    output updateMispredict,
    input  branchPredictValid, branchPredictData,
    input  predictIndex, mispredictCount
  );

  modport slave (
    input  enable, fetchAddress,
    input  updateValid, updateIndex, updateAddress,
    input  updateIsBranch, updateTaken, updateTarget,
    input  updateMispredict,
    output branchPredictValid, branchPredictData,
    output predictIndex, mispredictCount
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Tagged direct-mapped BTB with 2-bit counters, gshare indexing and a
// saturating mispredict counter. Ports: clock, reset, bus (slave modport).
module branch_target_predictor #(
  parameter int         ENTRIES      = 64,
  parameter int         TAG_BITS     = 8,
  parameter int         HISTORY_BITS = 4,
  parameter logic [1:0] COUNTER_INIT = 2'b01,
  parameter int         MISS_W       = 16
) (
  input logic clock,
  input logic reset,
  branch_target_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]  valid;
  logic [1:0]          ctr [ENTRIES];
  logic [TAG_BITS-1:0] tagMem [ENTRIES];
  logic [31:0]         targetMem [ENTRIES];

  logic [IDX_W-1:0]    ghrExt;
  logic [IDX_W-1:0]    fetchIdx;
  logic [IDX_W-1:0]    updIdx;
  logic [TAG_BITS-1:0] fetchTag;
  logic [TAG_BITS-1:0] updTag;
  logic                fetchHit;
  logic                updMatch;
  logic                branchUpd;
  logic [MISS_W-1:0]   missCount;
  logic                unusedAddr;

  assign unusedAddr = ^{bus.fetchAddress, bus.updateAddress};

  assign fetchTag = bus.fetchAddress[IDX_W+TAG_BITS+1:IDX_W+2];
  assign fetchIdx = bus.fetchAddress[IDX_W+1:2] ^ ghrExt;
  assign fetchHit = valid[fetchIdx] && (tagMem[fetchIdx] == fetchTag);

  assign bus.predictIndex       = fetchIdx;
  assign bus.branchPredictValid = bus.enable && fetchHit && ctr[fetchIdx][1];
  assign bus.branchPredictData  = fetchHit ? targetMem[fetchIdx] : 32'd0;
  assign bus.mispredictCount    = missCount;

  assign updIdx    = bus.updateIndex;
  assign updTag    = bus.updateAddress[IDX_W+TAG_BITS+1:IDX_W+2];
  assign updMatch  = valid[updIdx] && (tagMem[updIdx] == updTag);
  assign branchUpd = bus.updateValid && bus.updateIsBranch;

  // Global history; with zero length the index degenerates to bimodal.
  if (HISTORY_BITS == 0) begin : gNoHist
    assign ghrExt = '0;
  end else begin : gHist
    logic [HISTORY_BITS-1:0] ghr;
    logic [HISTORY_BITS:0]   ghrShift;

    assign ghrShift = {ghr, bus.updateTaken};
    assign ghrExt   = IDX_W'(ghr);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        ghr <= '0;
      end else if (branchUpd) begin
        ghr <= ghrShift[HISTORY_BITS-1:0];
      end
    end
  end

  // Valid bits, counters and miss count carry reset state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid     <= '0;
      missCount <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= COUNTER_INIT;
      end
    end else if (bus.updateValid) begin
      if (!bus.updateIsBranch) begin
        valid[updIdx] <= 1'b1;
        ctr[updIdx]   <= 2'b11;
      end else if (updMatch) begin
        if (bus.updateTaken) begin
          if (ctr[updIdx] != 2'b11) begin
            ctr[updIdx] <= ctr[updIdx] + 2'd1;
          end
        end else if (ctr[updIdx] != 2'b00) begin
          ctr[updIdx] <= ctr[updIdx] - 2'd1;
        end
      end else if (bus.updateTaken) begin
        valid[updIdx] <= 1'b1;
        ctr[updIdx]   <= 2'b10;
      end
      if (bus.updateMispredict && (missCount != '1)) begin
        missCount <= missCount + 1'b1;
      end
    end
  end

  // Tag/target need no reset: they are only observed through valid.
  // Any taken update (jump, retrain or allocate) writes both.
  always_ff @(posedge clock) begin
    if (bus.updateValid && !reset) begin
      if (!bus.updateIsBranch || bus.updateTaken) begin
        tagMem[updIdx]    <= updTag;
        targetMem[updIdx] <= bus.updateTarget;
      end
    end
  end
endmodule
